// File: rtl/param_menu_pkg.sv
// Shared types and helpers for the parameter menu selector.
package param_menu_pkg;

    typedef enum logic [1:0] {
        StIdle        = 2'd0,
        StBrowse      = 2'd1,
        StRestoreWait = 2'd2
    } state_e;

    localparam int unsigned CntW = 16;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
        return (&v) ? v : v + CntW'(1);
    endfunction

endpackage

// File: rtl/param_menu_key_filter.sv
// Synchronises one raw key and debounces it on the ms tick; emits level and press pulse.
module param_menu_key_filter import param_menu_pkg::*; #(
    parameter int unsigned DEBOUNCE_MS        = 20,
    parameter bit          KEY_RELEASED_VALUE = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic key_i,
    output logic pressed_o,
    output logic press_o
);

    logic [1:0]      sync_q;
    logic            pressed_q, pressed_d;
    logic            press_q, press_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            raw_pressed;

    assign raw_pressed = (sync_q[1] != KEY_RELEASED_VALUE);

    always_comb begin
        pressed_d = pressed_q;
        cnt_d     = cnt_q;
        // Any sample agreeing with the debounced level restarts the stability count.
        if (raw_pressed == pressed_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (sat_inc(cnt_q) >= CntW'(DEBOUNCE_MS)) begin
                pressed_d = raw_pressed;
                cnt_d     = '0;
            end else begin
                cnt_d = sat_inc(cnt_q);
            end
        end
        press_d = pressed_d & ~pressed_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q    <= {2{KEY_RELEASED_VALUE}};
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync_q    <= {sync_q[0], key_i};
            pressed_q <= pressed_d;
            press_q   <= press_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pressed_o = pressed_q;
    assign press_o   = press_q;

endmodule

// File: rtl/param_menu_selector.sv
// Menu controller: debounced NEXT/PREV/RESTORE keys drive a one-hot cell select and restore pulse.
// Optional idle timeout back to IDLE when PARAM_MENU_TIMEOUT_EN is defined.
module param_menu_selector import param_menu_pkg::*; #(
    parameter int unsigned NUM_PARAMS         = 8,
    parameter int unsigned DEBOUNCE_MS        = 20,
    parameter int unsigned RESTORE_HOLD_MS    = 1000,
    parameter int unsigned IDLE_TIMEOUT_MS    = 10000,
    parameter bit          KEY_RELEASED_VALUE = 1'b1,
    localparam int unsigned IDX_W             = idx_width(NUM_PARAMS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_ms,
    input  logic                  akey_next,
    input  logic                  akey_prev,
    input  logic                  akey_restore,
    output logic [NUM_PARAMS-1:0] selected,
    output logic [IDX_W-1:0]      sel_index,
    output logic                  restore,
    output logic                  menu_active
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_PARAMS - 1);

    logic            ms_s1_q, ms_s2_q, ms_s3_q;
    logic            tick;
    logic            press_next, press_prev, press_restore;
    logic            held_next, held_prev, restore_held;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      sel_idx_q, sel_idx_d;
    logic [CntW-1:0]       hold_q, hold_d;
    logic                  restore_q, restore_d;
    logic [NUM_PARAMS-1:0] selected_q, selected_d;
    logic                  menu_q, menu_d;
`ifdef PARAM_MENU_TIMEOUT_EN
    logic [CntW-1:0]       idle_q, idle_d;
    logic                  activity;
`endif

    assign tick = ms_s2_q & ~ms_s3_q;

    param_menu_key_filter #(
        .DEBOUNCE_MS       (DEBOUNCE_MS),
        .KEY_RELEASED_VALUE(KEY_RELEASED_VALUE)
    ) u_key_next (
        .clk_i    (clk),
        .rst_i    (reset),
        .tick_i   (tick),
        .key_i    (akey_next),
        .pressed_o(held_next),
        .press_o  (press_next)
    );

    param_menu_key_filter #(
        .DEBOUNCE_MS       (DEBOUNCE_MS),
        .KEY_RELEASED_VALUE(KEY_RELEASED_VALUE)
    ) u_key_prev (
        .clk_i    (clk),
        .rst_i    (reset),
        .tick_i   (tick),
        .key_i    (akey_prev),
        .pressed_o(held_prev),
        .press_o  (press_prev)
    );

    param_menu_key_filter #(
        .DEBOUNCE_MS       (DEBOUNCE_MS),
        .KEY_RELEASED_VALUE(KEY_RELEASED_VALUE)
    ) u_key_restore (
        .clk_i    (clk),
        .rst_i    (reset),
        .tick_i   (tick),
        .key_i    (akey_restore),
        .pressed_o(restore_held),
        .press_o  (press_restore)
    );

    always_comb begin
        state_d   = state_q;
        sel_idx_d = sel_idx_q;
        hold_d    = hold_q;
        restore_d = 1'b0;
        case (state_q)
            StIdle: begin
                hold_d = '0;
                if (press_next || press_prev) begin
                    state_d = StBrowse;
                end
            end
            StBrowse: begin
                if (press_next && !press_prev) begin
                    sel_idx_d = (sel_idx_q == LastIdx) ? '0 : sel_idx_q + IDX_W'(1);
                end else if (press_prev && !press_next) begin
                    sel_idx_d = (sel_idx_q == '0) ? LastIdx : sel_idx_q - IDX_W'(1);
                end
                if (!restore_held) begin
                    hold_d = '0;
                end else if (tick) begin
                    hold_d = sat_inc(hold_q);
                    if (hold_d >= CntW'(RESTORE_HOLD_MS)) begin
                        restore_d = 1'b1;
                        hold_d    = '0;
                        state_d   = StRestoreWait;
                    end
                end
            end
            StRestoreWait: begin
                hold_d = '0;
                if (!restore_held) begin
                    state_d = StBrowse;
                end
            end
            default: begin
                state_d = StIdle;
                hold_d  = '0;
            end
        endcase

`ifdef PARAM_MENU_TIMEOUT_EN
        activity = press_next | press_prev | restore_held;
        idle_d   = idle_q;
        if (state_q != StBrowse || activity) begin
            idle_d = '0;
        end else if (tick) begin
            idle_d = sat_inc(idle_q);
            if (idle_d >= CntW'(IDLE_TIMEOUT_MS)) begin
                idle_d  = '0;
                state_d = StIdle;
            end
        end
`endif

        menu_d     = (state_d != StIdle);
        selected_d = menu_d ? (NUM_PARAMS'(1) << sel_idx_d) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_s1_q    <= 1'b0;
            ms_s2_q    <= 1'b0;
            ms_s3_q    <= 1'b0;
            state_q    <= StIdle;
            sel_idx_q  <= '0;
            hold_q     <= '0;
            restore_q  <= 1'b0;
            selected_q <= '0;
            menu_q     <= 1'b0;
`ifdef PARAM_MENU_TIMEOUT_EN
            idle_q     <= '0;
`endif
        end else begin
            ms_s1_q    <= clk_ms;
            ms_s2_q    <= ms_s1_q;
            ms_s3_q    <= ms_s2_q;
            state_q    <= state_d;
            sel_idx_q  <= sel_idx_d;
            hold_q     <= hold_d;
            restore_q  <= restore_d;
            selected_q <= selected_d;
            menu_q     <= menu_d;
`ifdef PARAM_MENU_TIMEOUT_EN
            idle_q     <= idle_d;
`endif
        end
    end

    // Pressed levels of NEXT/PREV and the RESTORE press edge are not needed by the menu logic.
    logic unused_keys;
    assign unused_keys = held_next ^ held_prev ^ press_restore;

    assign selected    = selected_q;
    assign sel_index   = sel_idx_q;
    assign restore     = restore_q;
    assign menu_active = menu_q;

endmodule
